// File: rtl/rtc_bcd_alarm_if.sv
// Control/status bundle of the BCD real-time clock with alarm.
// The master side (bench or host) drives the strobes and set values;
// the slave side (the clock) drives the display digits and status flags.
interface rtc_bcd_alarm_if;
  logic        en;
  logic        mode_12h;
  logic        load;
  logic [23:0] load_time;
  logic        alarm_set;
  logic [15:0] alarm_time;
  logic        alarm_en;
  logic        alarm_ack;
  logic [3:0]  sec_ones;
  logic [3:0]  sec_tens;
  logic [3:0]  min_ones;
  logic [3:0]  min_tens;
  logic [3:0]  hr_ones;
  logic [3:0]  hr_tens;
  logic        pm;
  logic        tick;
  logic        alarm;
  logic        load_err;

  modport master (
    output en, mode_12h, load, load_time, alarm_set, alarm_time, alarm_en, alarm_ack,
    input  sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens, pm, tick, alarm, load_err
  );

  modport slave (
    input  en, mode_12h, load, load_time, alarm_set, alarm_time, alarm_en, alarm_ack,
    output sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens, pm, tick, alarm, load_err
  );
endinterface

// File: rtl/rtc_bcd_alarm.sv
// BCD real-time clock: prescaled one-second tick, 24-hour BCD time store,
// validated time/alarm loading, sticky alarm and 12/24-hour display mapping.
module rtc_bcd_alarm #(
  parameter int unsigned TICK_DIV = 32'd100000000
) (
  input  logic            clk,
  input  logic            rst,
  rtc_bcd_alarm_if.slave  bus
);

  // Legal 24-hour BCD time: every digit a decimal digit, tens of min/sec <= 5, hour <= 23.
  function automatic logic time_valid(input logic [23:0] t);
    return (t[23:16] <= 8'h23) && (t[19:16] <= 4'd9) && (t[15:12] <= 4'd5) &&
           (t[11:8] <= 4'd9) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
  endfunction

  // Legal alarm hh:mm, same digit rules as the time.
  function automatic logic alarm_valid(input logic [15:0] a);
    return (a[15:8] <= 8'h23) && (a[11:8] <= 4'd9) && (a[7:4] <= 4'd5) && (a[3:0] <= 4'd9);
  endfunction

  // One-second BCD increment with carries, 23:59:59 wrapping to 00:00:00.
  function automatic logic [23:0] time_inc(input logic [23:0] t);
    logic [23:0] n;
    n = t;
    if (t[3:0] != 4'd9) begin
      n[3:0] = t[3:0] + 4'd1;
    end else begin
      n[3:0] = 4'd0;
      if (t[7:4] != 4'd5) begin
        n[7:4] = t[7:4] + 4'd1;
      end else begin
        n[7:4] = 4'd0;
        if (t[11:8] != 4'd9) begin
          n[11:8] = t[11:8] + 4'd1;
        end else begin
          n[11:8] = 4'd0;
          if (t[15:12] != 4'd5) begin
            n[15:12] = t[15:12] + 4'd1;
          end else begin
            n[15:12] = 4'd0;
            if (t[23:16] == 8'h23) begin
              n[23:16] = 8'h00;
            end else if (t[19:16] != 4'd9) begin
              n[19:16] = t[19:16] + 4'd1;
            end else begin
              n[19:16] = 4'd0;
              n[23:20] = t[23:20] + 4'd1;
            end
          end
        end
      end
    end
    return n;
  endfunction

  logic [23:0] time_r, time_n;
  logic [31:0] presc_r, presc_n;
  logic [15:0] alarm_reg_r, alarm_reg_n;
  logic        alarm_r, alarm_n;
  logic        tick_r, tick_n;
  logic        load_err_r, load_err_n;
  logic        wrap_s, load_ok_s, load_bad_s, set_ok_s, set_bad_s, alarm_hit_s;

  // Next-state: load beats a coincident tick; alarm set beats ack/disarm.
  always_comb begin
    time_n      = time_r;
    presc_n     = presc_r;
    tick_n      = 1'b0;
    wrap_s      = bus.en && (presc_r == (TICK_DIV - 32'd1));
    load_ok_s   = bus.load && time_valid(bus.load_time);
    load_bad_s  = bus.load && !time_valid(bus.load_time);
    set_ok_s    = bus.alarm_set && alarm_valid(bus.alarm_time);
    set_bad_s   = bus.alarm_set && !alarm_valid(bus.alarm_time);
    if (load_ok_s) begin
      time_n  = bus.load_time;
      presc_n = 32'd0;
    end else if (wrap_s) begin
      time_n  = time_inc(time_r);
      presc_n = 32'd0;
      tick_n  = 1'b1;
    end else if (bus.en) begin
      presc_n = presc_r + 32'd1;
    end else begin
      presc_n = presc_r;
    end
    alarm_hit_s = tick_n && bus.alarm_en && (time_n == {alarm_reg_r, 8'h00});
    if (alarm_hit_s) begin
      alarm_n = 1'b1;
    end else if (bus.alarm_ack || !bus.alarm_en) begin
      alarm_n = 1'b0;
    end else begin
      alarm_n = alarm_r;
    end
    alarm_reg_n = set_ok_s ? bus.alarm_time : alarm_reg_r;
    load_err_n  = load_bad_s || set_bad_s;
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      time_r      <= 24'h000000;
      presc_r     <= 32'd0;
      alarm_reg_r <= 16'h0000;
      alarm_r     <= 1'b0;
      tick_r      <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      time_r      <= time_n;
      presc_r     <= presc_n;
      alarm_reg_r <= alarm_reg_n;
      alarm_r     <= alarm_n;
      tick_r      <= tick_n;
      load_err_r  <= load_err_n;
    end
  end

  logic [4:0] hour_bin_s, disp_bin_s;
  logic [3:0] hr_tens_s, hr_ones_s;

  // Display hour mapping: 00 -> 12, 13..23 -> 01..11 in 12-hour mode.
  always_comb begin
    hour_bin_s = ({1'b0, time_r[23:20]} * 5'd10) + {1'b0, time_r[19:16]};
    disp_bin_s = hour_bin_s;
    hr_tens_s  = time_r[23:20];
    hr_ones_s  = time_r[19:16];
    if (bus.mode_12h) begin
      if (hour_bin_s == 5'd0) begin
        disp_bin_s = 5'd12;
      end else if (hour_bin_s > 5'd12) begin
        disp_bin_s = hour_bin_s - 5'd12;
      end else begin
        disp_bin_s = hour_bin_s;
      end
      if (disp_bin_s >= 5'd10) begin
        hr_tens_s = 4'd1;
        hr_ones_s = disp_bin_s[3:0] - 4'd10;
      end else begin
        hr_tens_s = 4'd0;
        hr_ones_s = disp_bin_s[3:0];
      end
    end else begin
      hr_tens_s = time_r[23:20];
      hr_ones_s = time_r[19:16];
    end
  end

  assign bus.hr_tens  = hr_tens_s;
  assign bus.hr_ones  = hr_ones_s;
  assign bus.min_tens = time_r[15:12];
  assign bus.min_ones = time_r[11:8];
  assign bus.sec_tens = time_r[7:4];
  assign bus.sec_ones = time_r[3:0];
  assign bus.pm       = (hour_bin_s >= 5'd12);
  assign bus.tick     = tick_r;
  assign bus.alarm    = alarm_r;
  assign bus.load_err = load_err_r;

endmodule

// File: doc/rtc_bcd_alarm.md
RTC_BCD_ALARM -- requirements
Module: rtc_bcd_alarm

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clock cycles per one-second tick; legal range 1..2^32-1, and 1 means every enabled cycle ticks.
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  count enable; 0 freezes prescaler and time.
REQ-005 SHALL have port mode_12h  input  1  display format: 1 = 12-hour, 0 = 24-hour.
REQ-006 SHALL have port load  input  1  time-set strobe.
REQ-007 SHALL have port load_time  input  24  BCD {hr_tens,hr_ones,min_tens,min_ones,sec_tens,sec_ones}, always 24-hour.
REQ-008 SHALL have port alarm_set  input  1  alarm-register write strobe.
REQ-009 SHALL have port alarm_time  input  16  BCD {hr_tens,hr_ones,min_tens,min_ones}, 24-hour.
REQ-010 SHALL have port alarm_en  input  1  alarm arm.
REQ-011 SHALL have port alarm_ack  input  1  alarm clear.
REQ-012 SHALL have ports sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens  output  4 each  displayed BCD digits.
REQ-013 SHALL have port pm  output  1  1 when internal hour >= 12, in both modes.
REQ-014 SHALL have port tick  output  1  one-cycle pulse on every seconds increment.
REQ-015 SHALL have port alarm  output  1  level, sticky until cleared.
REQ-016 SHALL have port load_err  output  1  one-cycle pulse on a rejected load or alarm_set.

Function
REQ-017 SHALL hold time internally as 24-hour BCD, range 00:00:00..23:59:59.
REQ-018 SHALL count prescaler 0..TICK_DIV-1 while en=1; the edge where prescaler = TICK_DIV-1 wraps it to 0, increments time, and asserts tick in the same registered cycle.
REQ-019 SHALL carry seconds 59->00 into minutes, minutes 59->00 into hours, and wrap 23:59:59->00:00:00 with tick asserted.
REQ-020 SHALL, with en=0, hold prescaler and time with tick=0; counting resumes from the held prescaler value.
REQ-021 SHALL accept load when every digit <= 9, sec_tens <= 5, min_tens <= 5 and hour <= 23: time <= load_time and prescaler <= 0 on the next edge, tick=0 that cycle.
REQ-022 SHALL ignore an invalid load, leaving time and prescaler unchanged, and pulse load_err for one cycle.
REQ-023 SHALL give load priority over a coincident tick; the tick is dropped.
REQ-024 SHALL validate alarm_set the same way (hour <= 23, min_tens <= 5, digits <= 9): a valid value writes the alarm register; an invalid one is ignored and pulses load_err. If load and alarm_set are both invalid in the same cycle, load_err is a single pulse.
REQ-025 SHALL set alarm on the edge where a tick makes time equal alarm_hh:alarm_mm:00 while alarm_en=1; a load matching the alarm time SHALL NOT set alarm.
REQ-026 SHALL clear alarm on alarm_ack=1 or alarm_en=0; a set condition in the same cycle as alarm_ack SHALL win, so alarm stays 1.
REQ-027 SHALL, when mode_12h=0, output the internal digits directly.
REQ-028 SHALL, when mode_12h=1, display internal hour 00 as 12, hours 13..23 as 01..11, and hours 01..12 unchanged. Minutes and seconds are unaffected. Conversion is combinational from the registers, so the display has zero latency after a state update.

Reset
REQ-029 SHALL give rst=1 priority over all other inputs.
REQ-030 SHALL set on reset: time 00:00:00, prescaler 0, alarm register 00:00, alarm=0, tick=0, load_err=0.
REQ-031 SHALL make reset take effect on the first clk edge with rst=1, including mid-count and with alarm asserted.

Verification (TICK_DIV=4 unless noted)
REQ-032 SHALL cover reset then en=1 for 12 cycles -> tick pulses on cycles 4, 8 and 12; display 00:00:03.
REQ-033 SHALL cover load 23:59:59, en=1, 4 cycles -> 00:00:00 with tick=1, pm 1->0; with mode_12h=1 the display is 12:00:00.
REQ-034 SHALL cover load 13:05:00 with mode_12h=1 -> display 01:05:00, pm=1; then load 0x256000 (hour 25) -> time unchanged, load_err one-cycle pulse.
REQ-035 SHALL cover alarm_set 07:30, alarm_en=1, load 07:29:59, 4 cycles -> alarm=1 after the tick. Then alarm_ack coincident with no match -> alarm=0 next edge. A direct load of 07:30:00 -> alarm stays 0.
REQ-036 SHALL cover load asserted on a prescaler-wrap edge -> load value taken, no tick, and the next tick comes TICK_DIV cycles later.
REQ-037 SHALL cover TICK_DIV=1 with en toggling 1,0,1 -> time advances only on en=1 cycles; rst mid-count -> 00:00:00 next edge.
